var_state_array: RTL
====================

// Module: var_state_array
// PURPOSE
//  Holds value/level state for NUM_VARS variables of one Sat Engine bin: decide, imply, conflict analysis, backtrack, load/store.
//  Generalised successor of the fixed 2-variable state pair, adding a sequenced analyze operation with busy/done handshake.
//  Sits between the decision/control FSM and the clause array; var_value_o feeds the clause array, var_value_i returns from it.
// PARAMETERS
//  NUM_VARS  8   variables held; any value >= 1
//  LEVEL_W   10  decision-level width
//  (localparam) WIDTH_VAR_STATES = 3+LEVEL_W; per-var packed state is {dec, val[1:0], level}
// PORTS
//  clk                    in   1                     clock
//  rst                    in   1                     reset: synchronous, active-high
//  var_value_i            in   3*NUM_VARS            per var {impl_reason, val[1:0]} from clause array
//  var_value_o            out  3*NUM_VARS            per var stored {dec, val[1:0]}
//  valid_from_decision_i  in   NUM_VARS              one-hot decide strobe
//  cur_level_i            in   LEVEL_W               current decision level
//  apply_imply_i          in   1                     accept implications this cycle
//  find_imply_o           out  1                     >=1 new implication stored (registered)
//  find_conflict_o        out  1                     conflict detected (registered)
//  apply_analyze_i        in   1                     start analyze (pulse)
//  learned_mask_o         out  NUM_VARS              vars in learned clause, valid with done_o
//  max_level_o            out  LEVEL_W               backtrack level, valid with done_o
//  busy_o / done_o        out  1 / 1                 analyze in progress / 1-cycle completion pulse
//  apply_bkt_i            in   1                     backtrack strobe
//  bkt_lvl_i              in   LEVEL_W               backtrack target level
//  wr_states              in   NUM_VARS              per-var load enable
//  vars_states_i          in   WIDTH_VAR_STATES*NUM_VARS  load data; var k at [k*W +: W]
//  vars_states_o          out  WIDTH_VAR_STATES*NUM_VARS  current packed state
// BEHAVIOUR
//  - val encoding: 00 free, 01 true, 10 false, 11 conflict. Reset: all state 0, all outputs 0, FSM IDLE.
//  - All ops take effect on the clk edge. Priority in one cycle: wr_states > apply_bkt_i > apply_analyze_i > decide > imply.
//  - Decide: var k with strobe stores val=var_value_i[k].val, level=cur_level_i, dec=1. Decide on a non-free var: ignored.
//  - Imply (apply_imply_i): free var with input 01/10 stores it, level=cur_level_i, dec=0; find_imply_o=1 next cycle.
//    Input 11, or assigned var with opposite input -> find_conflict_o=1 next cycle, state unchanged. Both flags may be 1.
//  - Analyze FSM IDLE->RUN->IDLE: involved = (input val==11); learn = involved & (level!=cur_level | dec | !impl_reason).
//    max_level_o = max level over learn vars with level<cur_level_i, 0 if none. Without macro: done_o 1 cycle after start.
//    busy_o high in RUN; outputs hold until next analyze. apply_analyze_i, decide and imply ignored while busy_o.
//  - Backtrack: every var with level > bkt_lvl_i cleared (state 0); level == bkt_lvl_i kept. Aborts RUN, no done_o.
//  - wr_states[k]: var k state = vars_states_i slice verbatim. Overrides any op on that var; others proceed.
//  - rst mid-analyze: FSM -> IDLE, done_o not pulsed.
// CONFIGURATION
//  VAR_STATE_MAX_PIPE_EN: defined -> max/mask reduction is a registered binary tree, one stage per level;
//   done_o at start + ceil(log2 NUM_VARS) + 1 cycles (NUM_VARS=1 -> 1). Undefined -> combinational tree, done_o at start+1.
//  Results identical either way.
// STRUCTURE
//  Package sat_engine_pkg: val encodings (VAL_FREE/TRUE/FALSE/CONFLICT), LEVEL_W default, state pack/unpack functions.
//  Sub-module var_state_slot: one variable's registers, decide/imply/bkt/load; generate NUM_VARS copies.
//  Top: OR-reduce imply/conflict, analyze FSM, max-level reduction tree.
// TESTING
//  1. rst with NUM_VARS=8 -> all outputs 0; decide var3 val 01 lvl 5 -> var_value_o[3]={1,01}, vars_states_o level 5.
//  2. Imply var1=10 at lvl 5 (free) -> find_imply_o=1; var1 assigned 01 gets 10 -> find_conflict_o=1, var1 unchanged.
//  3. Vars lvl {2,4,5dec,5impl}, all input 11, cur 5 -> learned_mask marks first 3, max_level_o=4, done_o per macro latency.
//  4. Levels {1,3,3,6}, bkt_lvl 3 -> only lvl-6 var cleared; bkt during RUN -> no done_o, busy_o low next cycle.
//  5. wr_states=8'h01 with decide on var0 same cycle -> load data wins; vars_states_o readback equals load.
//  6. Run 3 and 4 with and without VAR_STATE_MAX_PIPE_EN, NUM_VARS in {1,5,8} -> identical results, latency 1 vs log2+1.

Source files
------------

// File: rtl/var_state_array_pkg.sv
// Shared value encodings and state-word helpers for the Sat Engine variable-state logic.
package sat_engine_pkg;

  localparam logic [1:0] VAL_FREE     = 2'b00;
  localparam logic [1:0] VAL_TRUE     = 2'b01;
  localparam logic [1:0] VAL_FALSE    = 2'b10;
  localparam logic [1:0] VAL_CONFLICT = 2'b11;

  localparam int LEVEL_W_DEF = 10;
  localparam int STATE_MAX_W = 64;

  typedef logic [STATE_MAX_W-1:0] state_word_t;

  // State words are {dec, val[1:0], level}; lw is the level width of the caller.
  function automatic state_word_t state_pack(input logic dec, input logic [1:0] val,
                                             input state_word_t level, input int lw);
    state_word_t w;
    w = level;
    w[lw +: 2] = val;
    w[lw + 2] = dec;
    return w;
  endfunction

  function automatic logic [1:0] state_val(input state_word_t st, input int lw);
    return st[lw +: 2];
  endfunction

  function automatic logic state_dec(input state_word_t st, input int lw);
    return st[lw + 2];
  endfunction

endpackage

// File: rtl/var_state_array_if.sv
// Analyze handshake between the decision/control FSM (master) and var_state_array (slave).
interface var_state_array_if
  import sat_engine_pkg::*;
#(
  parameter int NUM_VARS = 8,
  parameter int LEVEL_W  = LEVEL_W_DEF
);
  logic                apply_analyze_i;
  logic                busy_o;
  logic                done_o;
  logic [NUM_VARS-1:0] learned_mask_o;
  logic [LEVEL_W-1:0]  max_level_o;

  modport master (output apply_analyze_i, input busy_o, done_o, learned_mask_o, max_level_o);
  modport slave  (input apply_analyze_i, output busy_o, done_o, learned_mask_o, max_level_o);
endinterface

// File: rtl/var_state_array_slot.sv
// One variable's {dec, val, level} registers with load, backtrack, decide and imply updates.
module var_state_slot
  import sat_engine_pkg::*;
#(
  parameter int LEVEL_W = LEVEL_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           val_in,
  input  logic [LEVEL_W-1:0]   cur_level,
  input  logic                 decide_en,
  input  logic                 imply_en,
  input  logic                 bkt_en,
  input  logic [LEVEL_W-1:0]   bkt_lvl,
  input  logic                 wr_en,
  input  logic [LEVEL_W+2:0]   wr_data,
  output logic [LEVEL_W+2:0]   state,
  output logic                 imply_hit,
  output logic                 conflict_hit
);
  localparam int W = 3 + LEVEL_W;

  logic               dec_q;
  logic [1:0]         val_q;
  logic [LEVEL_W-1:0] lvl_q;
  logic               is_free, in_assign, opposite;

  assign is_free   = (val_q == VAL_FREE);
  assign in_assign = (val_in == VAL_TRUE) || (val_in == VAL_FALSE);
  assign opposite  = ((val_q == VAL_TRUE) && (val_in == VAL_FALSE)) ||
                     ((val_q == VAL_FALSE) && (val_in == VAL_TRUE));

  // A var being loaded this cycle takes no part in implication or conflict reporting.
  assign imply_hit    = imply_en && !wr_en && is_free && in_assign;
  assign conflict_hit = imply_en && !wr_en && ((val_in == VAL_CONFLICT) || opposite);

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_q <= 1'b0;
      val_q <= VAL_FREE;
      lvl_q <= '0;
    end else if (wr_en) begin
      dec_q <= state_dec(STATE_MAX_W'(wr_data), LEVEL_W);
      val_q <= state_val(STATE_MAX_W'(wr_data), LEVEL_W);
      lvl_q <= wr_data[LEVEL_W-1:0];
    end else if (bkt_en) begin
      if (lvl_q > bkt_lvl) begin
        dec_q <= 1'b0;
        val_q <= VAL_FREE;
        lvl_q <= '0;
      end
    end else if (decide_en && is_free) begin
      dec_q <= 1'b1;
      val_q <= val_in;
      lvl_q <= cur_level;
    end else if (imply_hit) begin
      dec_q <= 1'b0;
      val_q <= val_in;
      lvl_q <= cur_level;
    end
  end

  assign state = W'(state_pack(dec_q, val_q, STATE_MAX_W'(lvl_q), LEVEL_W));
endmodule

// File: rtl/var_state_array.sv
// Per-bin variable state array with decide/imply/backtrack/load and a sequenced analyze.
// Define VAR_STATE_MAX_PIPE_EN to register each level of the max-level reduction tree.
module var_state_array
  import sat_engine_pkg::*;
#(
  parameter int NUM_VARS = 8,
  parameter int LEVEL_W  = LEVEL_W_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [3*NUM_VARS-1:0]             var_value_i,
  output logic [3*NUM_VARS-1:0]             var_value_o,
  input  logic [NUM_VARS-1:0]               valid_from_decision_i,
  input  logic [LEVEL_W-1:0]                cur_level_i,
  input  logic                              apply_imply_i,
  output logic                              find_imply_o,
  output logic                              find_conflict_o,
  input  logic                              apply_bkt_i,
  input  logic [LEVEL_W-1:0]                bkt_lvl_i,
  input  logic [NUM_VARS-1:0]               wr_states,
  input  logic [(3+LEVEL_W)*NUM_VARS-1:0]   vars_states_i,
  output logic [(3+LEVEL_W)*NUM_VARS-1:0]   vars_states_o,
  var_state_array_if.slave                  ana
);
  localparam int WIDTH_VAR_STATES = 3 + LEVEL_W;
  localparam int DEPTH  = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 0;
  localparam int LEAVES = 1 << DEPTH;
`ifdef VAR_STATE_MAX_PIPE_EN
  localparam int STAGES = DEPTH;
`else
  localparam int STAGES = 0;
`endif
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]          state_q;
  logic [7:0]          cnt_q;
  logic                busy, start, ops_open, imply_ok;
  logic [NUM_VARS-1:0] imply_hits, conflict_hits, learn, mask_snap, mask_q;
  logic [LEVEL_W-1:0]  leaf_lvl [LEAVES];
  logic [LEVEL_W-1:0]  root, max_q;
  logic                done_q;

  assign busy     = (state_q == ST_RUN);
  assign start    = !busy && ana.apply_analyze_i && !apply_bkt_i;
  assign ops_open = !busy && !apply_bkt_i && !ana.apply_analyze_i;
  assign imply_ok = ops_open && apply_imply_i && !(|valid_from_decision_i);

  for (genvar k = 0; k < NUM_VARS; k++) begin : g_slot
    var_state_slot #(.LEVEL_W(LEVEL_W)) u_slot (
      .clk          (clk),
      .rst          (rst),
      .val_in       (var_value_i[3*k +: 2]),
      .cur_level    (cur_level_i),
      .decide_en    (ops_open && valid_from_decision_i[k]),
      .imply_en     (imply_ok),
      .bkt_en       (apply_bkt_i),
      .bkt_lvl      (bkt_lvl_i),
      .wr_en        (wr_states[k]),
      .wr_data      (vars_states_i[k*WIDTH_VAR_STATES +: WIDTH_VAR_STATES]),
      .state        (vars_states_o[k*WIDTH_VAR_STATES +: WIDTH_VAR_STATES]),
      .imply_hit    (imply_hits[k]),
      .conflict_hit (conflict_hits[k])
    );
    assign var_value_o[3*k +: 3] = vars_states_o[k*WIDTH_VAR_STATES + LEVEL_W +: 3];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      find_imply_o    <= 1'b0;
      find_conflict_o <= 1'b0;
    end else begin
      find_imply_o    <= |imply_hits;
      find_conflict_o <= |conflict_hits;
    end
  end

  // Leaves carry a learned var's level only if it is below the current level; padding leaves stay 0.
  always_comb begin
    logic [LEVEL_W-1:0] lvl;
    logic               dec;
    lvl   = '0;
    dec   = 1'b0;
    learn = '0;
    for (int i = 0; i < LEAVES; i++) leaf_lvl[i] = '0;
    for (int k = 0; k < NUM_VARS; k++) begin
      lvl = vars_states_o[k*WIDTH_VAR_STATES +: LEVEL_W];
      dec = vars_states_o[k*WIDTH_VAR_STATES + LEVEL_W + 2];
      learn[k] = (var_value_i[3*k +: 2] == VAL_CONFLICT) &&
                 ((lvl != cur_level_i) || dec || !var_value_i[3*k + 2]);
      if (learn[k] && (lvl < cur_level_i)) leaf_lvl[k] = lvl;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) mask_snap <= '0;
    else if (start) mask_snap <= learn;
  end

`ifdef VAR_STATE_MAX_PIPE_EN
  logic [LEVEL_W-1:0] node_q [1:2*LEAVES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < 2*LEAVES; i++) node_q[i] <= '0;
    end else begin
      if (start) for (int i = 0; i < LEAVES; i++) node_q[LEAVES+i] <= leaf_lvl[i];
      for (int i = 1; i < LEAVES; i++)
        node_q[i] <= (node_q[2*i] > node_q[2*i+1]) ? node_q[2*i] : node_q[2*i+1];
    end
  end
  assign root = node_q[1];
`else
  logic [LEVEL_W-1:0] leaf_q [LEAVES];
  logic [LEVEL_W-1:0] node   [1:2*LEAVES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LEAVES; i++) leaf_q[i] <= '0;
    end else if (start) begin
      for (int i = 0; i < LEAVES; i++) leaf_q[i] <= leaf_lvl[i];
    end
  end

  always_comb begin
    for (int i = 0; i < LEAVES; i++) node[LEAVES+i] = leaf_q[i];
    for (int i = LEAVES-1; i >= 1; i--)
      node[i] = (node[2*i] > node[2*i+1]) ? node[2*i] : node[2*i+1];
  end
  assign root = node[1];
`endif

  // Backtrack aborts a running analyze without a done pulse; results hold until the next completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      mask_q  <= '0;
      max_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (apply_bkt_i) begin
        state_q <= ST_IDLE;
      end else if (start) begin
        state_q <= ST_RUN;
        cnt_q   <= '0;
      end else if (busy) begin
        if (cnt_q == 8'(STAGES)) begin
          state_q <= ST_IDLE;
          done_q  <= 1'b1;
          mask_q  <= mask_snap;
          max_q   <= root;
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
      end
    end
  end

  assign ana.busy_o         = busy;
  assign ana.done_o         = done_q;
  assign ana.learned_mask_o = mask_q;
  assign ana.max_level_o    = max_q;
endmodule
